out_cmd_rx: RTL and testbench

SPI command receiver for the 8×8 interlock output path. It accepts framed switch commands from the host MCU and validates each one for header, length, padding, checksum and pair/endpoint interlock. Valid commands update the `outP[1:8]` / `out[1:28]` vectors atomically; these vectors feed the break-before-make output sequencer directly. A link watchdog forces both vectors to all-zero if valid frames stop arriving.

---
 rtl/out_cmd_rx.sv | 167 ++++++++++++++++
 tb/tb_out_cmd_rx.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/out_cmd_rx.sv
// out_cmd_rx: SPI command receiver driving the 8x8 interlock output vectors.
// Define OUT_CMD_RX_INTERLOCK_EN to reject frames enabling a pair whose two channels are both on.
module out_cmd_rx #(
    parameter int unsigned TIMEOUT_CYC = 25_000_000
) (
    input  logic        pclk_50M,
    input  logic        rst_n,
    input  logic        spi_sclk,
    input  logic        spi_mosi,
    input  logic        spi_cs_n,
    output logic [1:8]  outP,
    output logic [1:28] out,
    output logic        frame_ok,
    output logic        frame_err,
    output logic        timeout,
    output logic [7:0]  err_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        CHECK,
        COMMIT,
        REJECT
    } state_t;

    localparam logic [31:0] WD_LAST = TIMEOUT_CYC - 32'd1;

    state_t      state_q;
    logic [2:0]  sclk_q;
    logic [1:0]  mosi_q;
    logic [2:0]  cs_q;
    logic [55:0] sr_q;
    logic [5:0]  cnt_q;
    logic [31:0] wd_q;

    logic        sclk_rise;
    logic        cs_fall;
    logic        cs_rise;
    logic        wd_expire;
    logic [5:0]  cnt_d;
    logic [7:0]  f_hdr;
    logic [1:8]  f_outp;
    logic [1:28] f_out;
    logic [3:0]  f_pad;
    logic [7:0]  f_sum;
    logic        sum_ok;
    logic        ilk_ok;
    logic        frame_valid;

    // Bits [0],[1] synchronise, bit [2] holds history for edge detection
    always_ff @(posedge pclk_50M or negedge rst_n) begin
        if (!rst_n) begin
            sclk_q <= '0;
            mosi_q <= '0;
            // Low reset: a cs_n held low across reset release is not a falling edge
            cs_q   <= '0;
        end else begin
            sclk_q <= {sclk_q[1:0], spi_sclk};
            mosi_q <= {mosi_q[0], spi_mosi};
            cs_q   <= {cs_q[1:0], spi_cs_n};
        end
    end

    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign cs_fall   = ~cs_q[1] & cs_q[2];
    assign cs_rise   = cs_q[1] & ~cs_q[2];
    assign wd_expire = (wd_q == WD_LAST);
    assign cnt_d     = (cnt_q == 6'd63) ? cnt_q : cnt_q + 6'd1;

    assign f_hdr  = sr_q[55:48];
    assign f_outp = sr_q[47:40];
    assign f_out  = sr_q[39:12];
    assign f_pad  = sr_q[11:8];
    assign f_sum  = sr_q[7:0];

    assign sum_ok = (sr_q[47:40] ^ sr_q[39:32] ^ sr_q[31:24]
                   ^ sr_q[23:16] ^ sr_q[15:8]) == f_sum;

`ifdef OUT_CMD_RX_INTERLOCK_EN
    logic [1:28] pair_both;

    // Pair k = (i,j), i<j, enumerated column-wise: k = (j-1)(j-2)/2 + i
    for (genvar j = 2; j <= 8; j++) begin : g_hi
        for (genvar i = 1; i < j; i++) begin : g_lo
            assign pair_both[(j-1)*(j-2)/2 + i] = f_outp[i] & f_outp[j];
        end
    end

    assign ilk_ok = ~|(pair_both & f_out);
`else
    assign ilk_ok = 1'b1;
`endif

    assign frame_valid = (cnt_q == 6'd56)
                       && (f_hdr == 8'hA5)
                       && (f_pad == 4'h0)
                       && sum_ok
                       && ilk_ok;

    always_ff @(posedge pclk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sr_q      <= '0;
            cnt_q     <= '0;
            wd_q      <= '0;
            outP      <= '0;
            out       <= '0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            timeout   <= 1'b0;
            err_cnt   <= '0;
        end else begin
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            timeout   <= 1'b0;

            if (wd_expire) begin
                wd_q    <= '0;
                outP    <= '0;
                out     <= '0;
                timeout <= 1'b1;
            end else begin
                wd_q <= wd_q + 32'd1;
            end

            unique case (state_q)
                IDLE: begin
                    if (cs_fall) begin
                        sr_q    <= '0;
                        cnt_q   <= '0;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cs_rise) begin
                        state_q <= CHECK;
                    end else if (sclk_rise) begin
                        sr_q  <= {sr_q[54:0], mosi_q[1]};
                        cnt_q <= cnt_d;
                    end
                end
                CHECK: begin
                    // A commit overrides a coincident watchdog clear
                    if (frame_valid) begin
                        outP     <= f_outp;
                        out      <= f_out;
                        frame_ok <= 1'b1;
                        timeout  <= 1'b0;
                        wd_q     <= '0;
                        state_q  <= COMMIT;
                    end else begin
                        frame_err <= 1'b1;
                        if (err_cnt != 8'hFF) begin
                            err_cnt <= err_cnt + 8'd1;
                        end
                        state_q <= REJECT;
                    end
                end
                COMMIT:  state_q <= IDLE;
                REJECT:  state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_out_cmd_rx.sv
// Bench for out_cmd_rx: random SPI frames scored against a frame-level model.
`timescale 1ns/1ps
module tb_out_cmd_rx;

    localparam int TO = 2000;
    localparam int H  = 5;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        sclk  = 1'b0;
    logic        mosi  = 1'b0;
    logic        cs_n  = 1'b1;
    logic [1:8]  dP;
    logic [1:28] dO;
    logic        ok;
    logic        err;
    logic        to;
    logic [7:0]  ec;

    out_cmd_rx #(.TIMEOUT_CYC(TO)) dut (
        .pclk_50M (clk),
        .rst_n    (rst_n),
        .spi_sclk (sclk),
        .spi_mosi (mosi),
        .spi_cs_n (cs_n),
        .outP     (dP),
        .out      (dO),
        .frame_ok (ok),
        .frame_err(err),
        .timeout  (to),
        .err_cnt  (ec)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          t;
        logic        ok;
        logic        err;
        logic        to;
        logic [7:0]  p;
        logic [27:0] o;
        logic [7:0]  ec;
    } exp_t;

    exp_t q[$];
    int n_chk  = 0;
    int n_pass = 0;

    logic [7:0]  m_p = '0;
    logic [27:0] m_o = '0;
    int          m_ec = 0;
    int          anchor = 0;

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        n_chk++;
        if (a === e) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, a, e, cyc);
    endtask

    task automatic push(input int t, input logic k_ok, input logic k_err, input logic k_to);
        exp_t e;
        e.t = t; e.ok = k_ok; e.err = k_err; e.to = k_to;
        e.p = m_p; e.o = m_o; e.ec = 8'(m_ec);
        q.push_back(e);
    endtask

    // Watchdog clears the model due at or before cycle lim
    task automatic flush_upto(input int lim);
        while (anchor + TO <= lim) begin
            anchor += TO;
            m_p = '0;
            m_o = '0;
            push(anchor, 1'b0, 1'b0, 1'b1);
        end
    endtask

    task automatic frame_event(input int pc, input bit v,
                               input logic [7:0] p, input logic [27:0] o);
        flush_upto(pc - 1);
        if (v) begin
            m_p = p;
            m_o = o;
            anchor = pc;
            push(pc, 1'b1, 1'b0, 1'b0);
        end else begin
            if (m_ec < 255) m_ec++;
            if (anchor + TO == pc) begin
                m_p = '0;
                m_o = '0;
                anchor = pc;
                push(pc, 1'b0, 1'b1, 1'b1);
            end else begin
                push(pc, 1'b0, 1'b1, 1'b0);
            end
        end
    endtask

    function automatic bit judge(input logic [7:0] b [7], input int nbits);
        logic [31:0] w;
        bit v;
        int k;
        w = {b[2], b[3], b[4], b[5]};
        v = (nbits == 56) && (b[0] == 8'hA5) && (w[3:0] == 4'h0)
            && ((b[1] ^ b[2] ^ b[3] ^ b[4] ^ b[5]) == b[6]);
        k = 0;
`ifdef OUT_CMD_RX_INTERLOCK_EN
        for (int j = 2; j <= 8; j++) begin
            for (int i = 1; i < j; i++) begin
                k++;
                if (w[32-k] && b[1][8-i] && b[1][8-j]) v = 0;
            end
        end
`endif
        return v;
    endfunction

    task automatic idle(input int n);
        flush_upto(cyc + n);
        repeat (n) @(negedge clk);
    endtask

    task automatic shift_bit(input logic b);
        mosi = b;
        repeat (H) @(negedge clk);
        sclk = 1'b1;
        repeat (H) @(negedge clk);
        sclk = 1'b0;
    endtask

    // Result lands 4 cycles after the cs_n pin rise (2 sync + CHECK + load)
    task automatic send(input logic [7:0] b [7], input int nbits);
        logic [31:0] w;
        int pc;
        w  = {b[2], b[3], b[4], b[5]};
        pc = cyc + 8 + 10 * nbits + 4;
        frame_event(pc, judge(b, nbits), b[1], w[31:4]);
        cs_n = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < nbits; i++)
            shift_bit(i < 56 ? b[i/8][7-(i%8)] : 1'($urandom));
        repeat (4) @(negedge clk);
        cs_n = 1'b1;
        idle(10);
    endtask

    function automatic logic [7:0] xsum(input logic [7:0] b [7]);
        return b[1] ^ b[2] ^ b[3] ^ b[4] ^ b[5];
    endfunction

    task automatic rand_frame();
        logic [7:0] b [7];
        logic [31:0] w;
        int kind;
        int nb;
        kind = $urandom_range(0, 7);
        nb = 56;
        b[0] = 8'hA5;
        b[1] = 8'($urandom);
        w = $urandom;
        w[3:0] = 4'h0;
        if (kind == 1) begin
            b[1] = b[1] | 8'hC0;
            w[31] = 1'b1;
        end
        if (kind == 7) b[1] = 8'(1 << $urandom_range(0, 7));
        {b[2], b[3], b[4], b[5]} = w;
        if (kind == 2) b[0] = b[0] ^ 8'(1 << $urandom_range(0, 7));
        if (kind == 3) b[5] = b[5] | 8'(1 << $urandom_range(0, 3));
        b[6] = xsum(b);
        if (kind == 4) b[6] = b[6] ^ 8'(1 << $urandom_range(0, 7));
        if (kind == 5) nb = $urandom_range(1, 55);
        if (kind == 6) nb = $urandom_range(57, 70);
        send(b, nb);
    endtask

    initial begin : monitor
        exp_t e;
        string nm;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].t < cyc) begin
                n_chk++;
                $display("FAIL missed_event: expected at cycle %0d, none by %0d", q[0].t, cyc);
                void'(q.pop_front());
            end
            if (q.size() > 0 && q[0].t == cyc) begin
                e = q.pop_front();
                nm = e.ok ? "commit" : (e.err && e.to) ? "reject_timeout"
                   : e.err ? "reject" : "timeout";
                chk(nm, 64'({ok, err, to, dP, dO, ec}),
                        64'({e.ok, e.err, e.to, e.p, e.o, e.ec}));
            end else if (ok || err || to) begin
                chk("spurious_event", 64'({ok, err, to}), 64'(3'b000));
            end
        end
    end

    initial begin : stim
        logic [7:0] f [7];
        int x;
        #5 rst_n = 1'b0;
        repeat (5) @(negedge clk);
        chk("reset_state", 64'({dP, dO, ok, err, to, ec}), 64'(0));
        rst_n = 1'b1;
        anchor = cyc;
        idle(10);

        f = '{8'hA5, 8'h81, 8'h80, 8'h00, 8'h00, 8'h00, 8'h01};
        send(f, 56);
        f[6] = 8'h00;
        send(f, 56);
        f[6] = 8'h01;
        send(f, 40);
        send(f, 57);
        f = '{8'hA5, 8'hC0, 8'h80, 8'h00, 8'h00, 8'h00, 8'h40};
        send(f, 56);

        f = '{8'hA5, 8'h18, 8'h00, 8'h40, 8'h00, 8'h10, 8'h48};
        send(f, 56);
        idle(TO + 20);

        f = '{8'hA5, 8'h24, 8'h00, 8'h00, 8'h80, 8'h00, 8'hA4};
        send(f, 56);
        idle(anchor + TO - 572 - cyc);
        f = '{8'hA5, 8'h42, 8'h01, 8'h00, 8'h00, 8'h00, 8'h43};
        send(f, 56);
        idle(anchor + TO - 572 - cyc);
        f[6] = 8'h00;
        send(f, 56);

        f = '{8'hA5, 8'h11, 8'h00, 8'h20, 8'h00, 8'h00, 8'h31};
        send(f, 56);
        x = cyc + 4 + 300;
        flush_upto(x);
        cs_n = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 30; i++) shift_bit(f[i/8][7-(i%8)]);
        #2 rst_n = 1'b0;
        #1 chk("reset_midframe", 64'({dP, dO, ok, err, to, ec}), 64'(0));
        m_p = '0;
        m_o = '0;
        m_ec = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        anchor = cyc;
        for (int i = 0; i < 3; i++) begin
            sclk = 1'b1;
            idle(H);
            sclk = 1'b0;
            idle(H);
        end
        cs_n = 1'b1;
        idle(20);
        for (int i = 0; i < 3; i++) begin
            sclk = 1'b1;
            idle(H);
            sclk = 1'b0;
            idle(H);
        end
        f = '{8'hA5, 8'h81, 8'h80, 8'h00, 8'h00, 8'h00, 8'h01};
        send(f, 56);

        for (int i = 0; i < 30; i++) rand_frame();

        idle(30);
        chk("queue_drained", 64'(q.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
